dap_ahb_bridge: RTL

DAP_AHB_BRIDGE -- requirements
Module: dap_ahb_bridge

---
 rtl/dap_ahb_bridge.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dap_ahb_bridge.sv
// dap_ahb_bridge: DAP-to-AHB-Lite bridge, one single transfer in flight.
//   Sequence per request: IDLE -> ADDR -> DATA -> RESP -> IDLE.
// Ports:
//   DCLK, APRESETn        clock, synchronous active-low reset
//   DEVICEEN              debug enable; requests refused while low
//   SLVADDR/SLVWDATA/SLVTRANS/SLVWRITE/SLVSIZE   DAP request
//   SLVRDATA/SLVREADY/SLVRESP                    DAP response
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA AHB master outputs
//   HRDATA/HREADY/HRESP                          AHB slave response
// Build option: define DAP_AHB_ALIGN_CHECK_EN to refuse misaligned
//   halfword/word requests.
module dap_ahb_bridge #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        DCLK,
  input  logic        APRESETn,
  input  logic        DEVICEEN,
  input  logic [31:0] SLVADDR,
  input  logic [31:0] SLVWDATA,
  input  logic [1:0]  SLVTRANS,
  input  logic        SLVWRITE,
  input  logic [1:0]  SLVSIZE,
  output logic [31:0] SLVRDATA,
  output logic        SLVREADY,
  output logic        SLVRESP,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        write_q, err_q;
  logic        req, legal;
  logic        unused_trans0;

  always_comb begin
    req           = SLVTRANS[1];
    unused_trans0 = SLVTRANS[0];
    legal         = DEVICEEN && (SLVSIZE != 2'b11);
`ifdef DAP_AHB_ALIGN_CHECK_EN
    if ((SLVSIZE == 2'b01 && SLVADDR[0]) ||
        (SLVSIZE == 2'b10 && SLVADDR[1:0] != 2'b00))
      legal = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge DCLK) begin
    if (!APRESETn) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = legal ? ADDR : RESP;
      ADDR: if (HREADY) state_nxt = DATA;
      DATA: if (HREADY) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and response capture. Refused requests only set the
  // error flag so the read data register keeps its previous value.
  always_ff @(posedge DCLK) begin
    if (!APRESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (legal) begin
              addr_q  <= SLVADDR;
              wdata_q <= SLVWDATA;
              size_q  <= SLVSIZE;
              write_q <= SLVWRITE;
              err_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        // HRESP seen with HREADY low is the first error cycle; only the
        // completing cycle is sampled.
        DATA: begin
          if (HREADY) begin
            err_q <= HRESP;
            if (!write_q) rdata_q <= HRDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    SLVREADY = (state == RESP);
    SLVRESP  = (state == RESP) && err_q;
    SLVRDATA = rdata_q;
    HTRANS   = (state == ADDR) ? 2'b10 : 2'b00;
    HADDR    = addr_q;
    HWRITE   = write_q;
    HSIZE    = {1'b0, size_q};
    HWDATA   = wdata_q;
    HBURST   = '0;
    HPROT    = HPROT_VAL;
  end

endmodule
